// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared control definitions for the decode-stage main control unit and the
// execute-stage ALU control decoder: opcode constants, aluop encodings, the
// packed datapath control struct and the bubble (all-zero) control word.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Opcode field values (instruction bits [31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // aluop encodings consumed by the ALU control decoder
   localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
   localparam logic [1:0] ALUOP_LWSW    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH  = 2'b01;
   localparam logic [1:0] ALUOP_UNKNOWN = 2'b11;

   // Datapath control word produced by the main decoder
   typedef struct packed {
      logic [1:0] aluop;
      logic       regdst;
      logic       alusrc;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       branch;
   } ctrl_t;

   // Bubble: aluop 00 and every control bit cleared
   localparam ctrl_t CTRL_BUBBLE = ctrl_t'(9'b0_0000_0000);

endpackage : mips_ctrl_pkg

// File: rtl/main_decoder.sv
// ---------------------------------------------------------------------------
// main_decoder
// Purely combinational main control decoder.
// Ports:
//   opcode  in  [5:0]  instruction bits [31:26]
//   ctrl    out ctrl_t decoded aluop and datapath control bits
//   illegal out        opcode is not R-type, lw, sw or beq
// ---------------------------------------------------------------------------
module main_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_t      ctrl,
   output logic       illegal
);

   ctrl_t ctrl_s;
   logic  illegal_s;

   // Opcode decode; anything unrecognised gets aluop 11 and no side effects
   always_comb begin
      ctrl_s    = CTRL_BUBBLE;
      illegal_s = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl_s.aluop    = ALUOP_RTYPE;
            ctrl_s.regdst   = 1'b1;
            ctrl_s.regwrite = 1'b1;
         end
         OP_LW: begin
            ctrl_s.aluop    = ALUOP_LWSW;
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.memread  = 1'b1;
            ctrl_s.memtoreg = 1'b1;
            ctrl_s.regwrite = 1'b1;
         end
         OP_SW: begin
            ctrl_s.aluop    = ALUOP_LWSW;
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.memwrite = 1'b1;
         end
         OP_BEQ: begin
            ctrl_s.aluop    = ALUOP_BRANCH;
            ctrl_s.branch   = 1'b1;
         end
         default: begin
            ctrl_s.aluop    = ALUOP_UNKNOWN;
            illegal_s       = 1'b1;
         end
      endcase
   end

   assign ctrl    = ctrl_s;
   assign illegal = illegal_s;

endmodule : main_decoder

// File: rtl/id_ex_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl
// Decode-stage main control plus the ID/EX control pipeline register, with
// hazard-unit stall (hold) and flush (bubble) support.
// Optional feature macro: ID_EX_ILLEGAL_TRAP_EN enables the sticky illegal
// opcode flag and saturating illegal counter; without it both read 0.
// Ports:
//   clk, rst_n (sync active-low)        clock and reset
//   id_valid, id_opcode, id_funct       instruction in ID
//   stall, flush                        hazard-unit controls
//   illegal_clr                         clears sticky flag and counter
//   ex_valid, ex_aluop, ex_funct, ex_*  registered control to EX
//   illegal_sticky, illegal_cnt         illegal-opcode trap status
// ---------------------------------------------------------------------------
module id_ex_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [5:0]       id_funct,
   input  logic             stall,
   input  logic             flush,
   input  logic             illegal_clr,
   output logic             ex_valid,
   output logic [1:0]       ex_aluop,
   output logic [5:0]       ex_funct,
   output logic             ex_regdst,
   output logic             ex_alusrc,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_memtoreg,
   output logic             ex_regwrite,
   output logic             ex_branch,
   output logic             illegal_sticky,
   output logic [CNT_W-1:0] illegal_cnt
);

   ctrl_t      dec_ctrl_s;
   logic       dec_illegal_s;
   logic       latch_s;
   ctrl_t      ex_ctrl_r;
   logic       ex_valid_r;
   logic [5:0] ex_funct_r;

   main_decoder u_main_decoder (
      .opcode  (id_opcode),
      .ctrl    (dec_ctrl_s),
      .illegal (dec_illegal_s)
   );

   // An illegal opcode counts only when it actually loads into ID/EX
   always_comb begin
      if (!flush && !stall && id_valid) begin
         latch_s = dec_illegal_s;
      end else begin
         latch_s = 1'b0;
      end
   end

   // ID/EX register: reset > flush > stall (hold) > invalid (bubble) > load
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ex_valid_r <= 1'b0;
         ex_ctrl_r  <= CTRL_BUBBLE;
         ex_funct_r <= 6'b000000;
      end else if (stall) begin
         ex_valid_r <= ex_valid_r;
         ex_ctrl_r  <= ex_ctrl_r;
         ex_funct_r <= ex_funct_r;
      end else if (!id_valid) begin
         ex_valid_r <= 1'b0;
         ex_ctrl_r  <= CTRL_BUBBLE;
         ex_funct_r <= 6'b000000;
      end else begin
         ex_valid_r <= 1'b1;
         ex_ctrl_r  <= dec_ctrl_s;
         ex_funct_r <= id_funct;
      end
   end

`ifdef ID_EX_ILLEGAL_TRAP_EN
   logic             sticky_r;
   logic [CNT_W-1:0] cnt_r;

   // Trap status; a latch coinciding with a clear restarts the count at 1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_r <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
      end else if (latch_s) begin
         sticky_r <= 1'b1;
         if (illegal_clr) begin
            cnt_r <= CNT_W'(1'b1);
         end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end else begin
            cnt_r <= cnt_r;
         end
      end else if (illegal_clr) begin
         sticky_r <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         sticky_r <= sticky_r;
         cnt_r    <= cnt_r;
      end
   end

   assign illegal_sticky = sticky_r;
   assign illegal_cnt    = cnt_r;
`else
   // Trap disabled: status tied low, clear request has no effect
   logic unused_trap_s;
   assign unused_trap_s  = illegal_clr ^ latch_s;
   assign illegal_sticky = 1'b0;
   assign illegal_cnt    = {CNT_W{1'b0}};
`endif

   assign ex_valid    = ex_valid_r;
   assign ex_aluop    = ex_ctrl_r.aluop;
   assign ex_funct    = ex_funct_r;
   assign ex_regdst   = ex_ctrl_r.regdst;
   assign ex_alusrc   = ex_ctrl_r.alusrc;
   assign ex_memread  = ex_ctrl_r.memread;
   assign ex_memwrite = ex_ctrl_r.memwrite;
   assign ex_memtoreg = ex_ctrl_r.memtoreg;
   assign ex_regwrite = ex_ctrl_r.regwrite;
   assign ex_branch   = ex_ctrl_r.branch;

endmodule : id_ex_ctrl

// File: doc/id_ex_ctrl.md
# id_ex_ctrl

Decode-stage main control unit with an ID/EX control pipeline register. It decodes the 6-bit opcode of the instruction in ID and produces the 2-bit `aluop` and datapath control bits, then registers them together with the `funct` field. The registered `ex_aluop` / `ex_funct` pair drives the execute-stage ALU control decoder. The block supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- `CNT_W`, default 8: width of the illegal-opcode counter.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_opcode`, in, 6: instruction bits [31:26].
- `id_funct`, in, 6: instruction bits [5:0].
- `stall`, in, 1: hold the ID/EX register contents.
- `flush`, in, 1: load a bubble into the ID/EX register.
- `illegal_clr`, in, 1: clear the sticky illegal flag and the counter.
- `ex_valid`, out, 1: the registered instruction is real.
- `ex_aluop`, out, 2: 10 = R-type, 00 = lw/sw add, 01 = beq subtract, 11 = unknown.
- `ex_funct`, out, 6: registered funct field.
- `ex_regdst`, `ex_alusrc`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_regwrite`, `ex_branch`, out, 1 each: registered control bits.
- `illegal_sticky`, out, 1: an illegal opcode was latched since the last clear.
- `illegal_cnt`, out, `CNT_W`: saturating count of latched illegal opcodes.

## Operation
- Decode rules, applied to `id_opcode`:
  - 000000 (R-type): `aluop` 10, `regdst` 1, `regwrite` 1.
  - 100011 (lw): `aluop` 00, `alusrc` 1, `memread` 1, `memtoreg` 1, `regwrite` 1.
  - 101011 (sw): `aluop` 00, `alusrc` 1, `memwrite` 1.
  - 000100 (beq): `aluop` 01, `branch` 1.
  - Any other opcode: `aluop` 11, all control bits 0, `illegal` = 1.
- Control bits not listed for a decode case are 0.
- Bubble: `valid` 0, `aluop` 00, `funct` 000000, all control bits 0.
- Register update priority, evaluated each edge, highest first:
  1. `!rst_n`: load the bubble; clear `illegal_sticky` and `illegal_cnt`.
  2. `flush`: load the bubble. Flush beats a simultaneous stall.
  3. `stall`: hold every register, including `ex_valid`.
  4. `!id_valid`: load the bubble.
  5. Otherwise: load the decoded fields, set `ex_valid` to 1, and load `ex_funct` from `id_funct`.
- `ex_funct` is loaded unmodified for every opcode. It is only meaningful when `aluop` is 10.
- An illegal instruction is "latched" only in case 5 with `illegal` = 1. A flushed, stalled or invalid illegal opcode is not latched.

## Timing
- Latency: one cycle from ID inputs to `ex_*` outputs. No combinational path from inputs to outputs.
- Reset values: all `ex_*` outputs 0, `illegal_sticky` 0, `illegal_cnt` 0.
- A stall held N cycles keeps the outputs constant for N cycles. The instruction loads on the first edge after `stall` drops.
- Reset asserted mid-stall loads the bubble; reset beats both stall and flush.

## Configuration
- Macro: `ID_EX_ILLEGAL_TRAP_EN`.
- Defined:
  - Latching an illegal opcode sets `illegal_sticky` and increments `illegal_cnt`, which saturates at 2^`CNT_W`-1.
  - `illegal_clr` clears both on the next edge.
  - If `illegal_clr` coincides with a latch, the latch wins: sticky = 1, count = 1.
- Not defined: `illegal_sticky` and `illegal_cnt` are tied to 0 and `illegal_clr` is ignored. Decode, including `aluop` 11, is unchanged.

## Structure
- Shared package `mips_ctrl_pkg`, shared with the execute-stage ALU control decoder:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`);
  - aluop encodings (`ALUOP_RTYPE` = 10, `ALUOP_LWSW` = 00, `ALUOP_BRANCH` = 01, `ALUOP_UNKNOWN` = 11);
  - a packed control struct type;
  - the bubble constant.
- One combinational sub-module, `main_decoder`: opcode in, control struct plus `illegal` out. `id_ex_ctrl` holds the registers, priority logic and counter.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with opcode 100011 applied -> all outputs 0. Release with lw valid -> next edge `ex_aluop` 00 with `alusrc`, `memread`, `memtoreg`, `regwrite` = 1 and `ex_valid` 1.
- R-type opcode 000000 with funct 100010 -> `ex_aluop` 10, `ex_funct` 100010, `regdst` 1, `regwrite` 1. beq next cycle -> `ex_aluop` 01, `branch` 1, `regwrite` 0.
- Load sw, then assert `stall` for 3 cycles while ID changes to beq -> sw fields held for 3 cycles; beq appears on the edge after stall drops.
- `stall` and `flush` together with R-type in ID -> bubble loaded (`ex_valid` 0, `aluop` 00).
- Macro defined, opcode 111111 valid for 3 cycles -> `ex_aluop` 11, `illegal_sticky` 1, `illegal_cnt` 3. Same opcode with `flush` -> count unchanged. `illegal_clr` -> 0.
- Macro defined, `CNT_W`=2, 5 illegal latches -> `illegal_cnt` saturates at 3. Macro undefined -> outputs stay 0 while `ex_aluop` is still 11.
